// File: rtl/alu_seq.sv
// Multi-cycle RV32-style ALU with valid/ready handshakes on both sides.
// Shifts run one bit per cycle; the optional multiplier is shift-add, one multiplier bit per cycle.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_out,
    output logic             z_out,
    output logic             n_out
);

    localparam int CW = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    localparam logic [WIDTH-1:0] ILLEGAL_RES = {(WIDTH/2){2'b01}};

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, ma, mb;
    logic [CW-1:0]    cnt;
    logic [3:0]       op;

    logic             accept;
    logic             is_shift_in, is_mul_in;
    logic [SHW-1:0]   sh_in;
    logic [WIDTH-1:0] alu_res, shift_nx, mul_nx, fin_val;
    logic             fin_we;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid & in_ready;
    assign sh_in       = b_in[SHW-1:0];
    assign is_shift_in = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
    assign is_mul_in   = MUL_EN && (alu_op == OP_MUL);

    // Single-cycle result; a shift by zero simply passes operand A through.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        alu_res = ILLEGAL_RES;
        unique case (alu_op)
            OP_ADD:  alu_res = a_in + b_in;
            OP_SUB:  alu_res = a_in - b_in;
            OP_AND:  alu_res = a_in & b_in;
            OP_XOR:  alu_res = a_in ^ b_in;
            OP_OR:   alu_res = a_in | b_in;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_in) < $signed(b_in)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a_in < b_in};
            OP_SLL, OP_SRL, OP_SRA: alu_res = a_in;
            default: alu_res = ILLEGAL_RES;
        endcase
    end

    always_comb begin
        shift_nx = {acc[WIDTH-1], acc[WIDTH-1:1]};
        if (op == OP_SLL)
            shift_nx = {acc[WIDTH-2:0], 1'b0};
        else if (op == OP_SRL)
            shift_nx = {1'b0, acc[WIDTH-1:1]};
    end

    assign mul_nx = acc + (mb[0] ? ma : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state, plus the single write strobe for result and flags.
    always_comb begin
        state_nx = state;
        fin_we   = 1'b0;
        fin_val  = alu_res;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (is_shift_in && (sh_in != '0)) begin
                        state_nx = SHIFT;
                    end else if (is_mul_in) begin
                        state_nx = MUL;
                    end else begin
                        fin_we   = 1'b1;
                        fin_val  = alu_res;
                        state_nx = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt == CW'(1)) begin
                    fin_we   = 1'b1;
                    fin_val  = shift_nx;
                    state_nx = DONE;
                end
            end
            MUL: begin
                if (cnt == CW'(1)) begin
                    fin_we   = 1'b1;
                    fin_val  = mul_nx;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments; every register here is reset.
            acc        <= '0;
            ma         <= '0;
            mb         <= '0;
            cnt        <= '0;
            op         <= '0;
            result_out <= '0;
            z_out      <= 1'b0;
            n_out      <= 1'b0;
        end else begin
            if (accept) begin
                op  <= alu_op;
                ma  <= a_in;
                mb  <= b_in;
                acc <= is_mul_in ? '0 : a_in;
                cnt <= is_mul_in ? CW'(WIDTH) : {1'b0, sh_in};
            end else if (state == SHIFT) begin
                acc <= shift_nx;
                cnt <= cnt - 1'b1;
            end else if (state == MUL) begin
                acc <= mul_nx;
                ma  <= {ma[WIDTH-2:0], 1'b0};
                mb  <= {1'b0, mb[WIDTH-1:1]};
                cnt <= cnt - 1'b1;
            end
            // Flags only ever move together with the final result.
            if (fin_we) begin
                result_out <= fin_val;
                z_out      <= (fin_val == '0);
                n_out      <= fin_val[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq: single-cycle ops, iterative shifts and multiply,
// output back-pressure and asynchronous reset during an in-flight shift.
module tb_alu_seq;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ILL4 = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_ILLF = 4'b1111;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [7:0]  lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] a_in = '0, b_in = '0;
    logic [3:0]  alu_op = '0;
    logic        in_ready, out_valid, z_out, n_out;
    logic [31:0] result_out;

    logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
    logic [31:0] a_in2 = '0, b_in2 = '0;
    logic [3:0]  alu_op2 = '0;
    logic        in_ready2, out_valid2, z_out2, n_out2;
    logic [31:0] result_out2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .result_out(result_out), .z_out(z_out), .n_out(n_out)
    );

    alu_seq #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_in(a_in2), .b_in(b_in2), .alu_op(alu_op2), .out_valid(out_valid2),
        .out_ready(out_ready2), .result_out(result_out2), .z_out(z_out2), .n_out(n_out2)
    );

    // Present one op at a negedge; lat counts edges from the accept edge (=1) to out_valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = op;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = 32'hA5A5_A5A5;
        b_in     = 32'h5A5A_5A5A;
        alu_op   = OP_SUB;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        checks++;
        if (result_out !== 32'h0 || z_out !== 1'b0 || n_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs result=%h z=%b n=%b exp 0/0/0", result_out, z_out, n_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_cycle();
        vec_t vs[10];
        int lat;
        vs[0] = '{OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 8'd1};
        vs[1] = '{OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 8'd1};
        vs[2] = '{OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h0000_0001, 8'd1};
        vs[3] = '{OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 8'd1};
        vs[4] = '{OP_SUB,  32'h5,         32'h5,         32'h0000_0000, 8'd1};
        vs[5] = '{OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 8'd1};
        vs[6] = '{OP_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 8'd1};
        vs[7] = '{OP_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 8'd1};
        vs[8] = '{OP_ILL4, 32'h1234_5678, 32'h1,         32'h5555_5555, 8'd1};
        vs[9] = '{OP_ILLF, 32'h0,         32'h0,         32'h5555_5555, 8'd1};
        for (int i = 0; i < 10; i++) begin
            run_op(vs[i].op, vs[i].a, vs[i].b, lat);
            checks++;
            if (lat !== int'(vs[i].lat)) begin
                failures++;
                $display("FAIL single[%0d] latency got=%0d exp=%0d", i, lat, vs[i].lat);
            end
            checks++;
            if (result_out !== vs[i].res || z_out !== (vs[i].res == 32'h0) || n_out !== vs[i].res[31]) begin
                failures++;
                $display("FAIL single[%0d] result got=%h z=%b n=%b exp=%h z=%b n=%b", i, result_out,
                         z_out, n_out, vs[i].res, vs[i].res == 32'h0, vs[i].res[31]);
            end
            consume();
        end
    endtask

    task automatic test_shift();
        vec_t vs[6];
        int lat;
        vs[0] = '{OP_SRA, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 8'd32};
        vs[1] = '{OP_SRL, 32'h8000_0000, 32'd31,        32'h0000_0001, 8'd32};
        vs[2] = '{OP_SLL, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 8'd1};
        vs[3] = '{OP_SLL, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 8'd5};
        vs[4] = '{OP_SRA, 32'h8000_0000, 32'd4,         32'hF800_0000, 8'd5};
        vs[5] = '{OP_SRL, 32'hF000_000F, 32'd1,         32'h7800_0007, 8'd2};
        for (int i = 0; i < 6; i++) begin
            run_op(vs[i].op, vs[i].a, vs[i].b, lat);
            checks++;
            if (lat !== int'(vs[i].lat)) begin
                failures++;
                $display("FAIL shift[%0d] latency got=%0d exp=%0d", i, lat, vs[i].lat);
            end
            checks++;
            if (result_out !== vs[i].res || z_out !== (vs[i].res == 32'h0) || n_out !== vs[i].res[31]) begin
                failures++;
                $display("FAIL shift[%0d] result got=%h z=%b n=%b exp=%h", i, result_out, z_out, n_out,
                         vs[i].res);
            end
            consume();
        end
    endtask

    task automatic test_mul();
        vec_t vs[3];
        int lat;
        vs[0] = '{OP_MUL, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 8'd33};
        vs[1] = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 8'd33};
        vs[2] = '{OP_MUL, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 8'd33};
        for (int i = 0; i < 3; i++) begin
            run_op(vs[i].op, vs[i].a, vs[i].b, lat);
            checks++;
            if (lat !== int'(vs[i].lat)) begin
                failures++;
                $display("FAIL mul[%0d] latency got=%0d exp=%0d", i, lat, vs[i].lat);
            end
            checks++;
            if (result_out !== vs[i].res || z_out !== (vs[i].res == 32'h0) || n_out !== vs[i].res[31]) begin
                failures++;
                $display("FAIL mul[%0d] result got=%h z=%b n=%b exp=%h", i, result_out, z_out, n_out,
                         vs[i].res);
            end
            consume();
        end
        // Without the multiplier, MUL is an illegal opcode finishing in one cycle.
        @(negedge clk);
        in_valid2 = 1'b1;
        alu_op2   = OP_MUL;
        a_in2     = 32'hFFFF_FFFF;
        b_in2     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        checks++;
        if (out_valid2 !== 1'b1 || result_out2 !== 32'h5555_5555 || z_out2 !== 1'b0 || n_out2 !== 1'b0) begin
            failures++;
            $display("FAIL mul_disabled valid=%b result=%h exp valid=1 result=55555555", out_valid2, result_out2);
        end
        out_ready2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready2 = 1'b0;
        checks++;
        if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL mul_disabled_release valid=%b in_ready=%b exp 0/1", out_valid2, in_ready2);
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        int bad;
        run_op(OP_ADD, 32'd2, 32'd3, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            alu_op   = OP_SUB;
            a_in     = 32'd9;
            b_in     = 32'd1;
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || result_out !== 32'd5 || in_ready !== 1'b0 || z_out !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable bad_cycles got=%0d exp=0", bad);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result_out !== 32'd5) begin
            failures++;
            $display("FAIL hold_no_queue out_valid=%b result=%h exp 0/00000005", out_valid, result_out);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        int bad;
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = OP_SLL;
        a_in     = 32'h0000_0001;
        b_in     = 32'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_shift_busy in_ready=%b out_valid=%b exp 0/0", in_ready, out_valid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result_out !== 32'h0 || z_out !== 1'b0 ||
            n_out !== 1'b0) begin
            failures++;
            $display("FAIL async_reset in_ready=%b out_valid=%b result=%h z=%b n=%b exp 1/0/0/0/0",
                     in_ready, out_valid, result_out, z_out, n_out);
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_discard bad_cycles got=%0d exp=0", bad);
        end
        run_op(OP_ADD, 32'd2, 32'd3, lat);
        checks++;
        if (lat !== 1 || result_out !== 32'd5 || z_out !== 1'b0 || n_out !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_add lat=%0d result=%h exp lat=1 result=00000005", lat, result_out);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_shift();
        test_mul();
        test_back_pressure();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
